led_rate_tick_gen: RTL and testbench
====================================

# led_rate_tick_gen

Upstream timing stage for the running-light display. Divides the 50 MHz system clock into a one-cycle `tick` enable and a 50%-duty `clk_out` square wave; either one drives the LED shift register. The step rate is chosen at runtime from four binary-scaled speeds using two debounced push-buttons, and a third button pauses or resumes stepping. It replaces the fixed 1 Hz divider with a user-controllable source.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency in Hz.
- `BASE_HZ`, default 1: tick rate at speed level 0 in Hz.
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable cycles required to accept a key change (20 ms at 50 MHz).
- Parameter constraint: `CLK_HZ % (16*BASE_HZ) == 0`. This gives every level an even period of at least 2. The constraint is checked at elaboration.
- `sys_clk`, in, 1: single system clock. All logic is on the rising edge.
- `sys_rst`, in, 1: asynchronous, active-high reset.
- `key_up`, in, 1: raw speed-up button, active-low, asynchronous.
- `key_down`, in, 1: raw speed-down button, active-low, asynchronous.
- `key_pause`, in, 1: raw pause/resume button, active-low, asynchronous.
- `tick`, out, 1: one-`sys_clk` pulse, once per step period.
- `clk_out`, out, 1: square wave at the step rate.
- `level`, out, 2: current speed level, 0 to 3.
- `paused`, out, 1: high while stepping is suspended.

## Operation
- **Key synchronizer:** each key passes through a 2-FF synchronizer.
- **Debouncer (per key):**
  - Holds a debounced state, reset value 1 (released).
  - A counter runs while the synchronized value differs from the debounced state and clears whenever they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced state takes the new value and the counter clears.
- **Press event:** a 1→0 transition of the debounced state produces a one-cycle internal pulse. Release produces no event.
- **Level:**
  - An up press increments `level`, saturating at 3.
  - A down press decrements `level`, saturating at 0.
  - Up and down press pulses in the same cycle leave `level` unchanged.
  - A saturated press is ignored, with no prescaler restart.
- **Pause:** a pause press toggles `paused`. It may coincide with a level event; both take effect.
- **Period:** `P(level) = CLK_HZ / (BASE_HZ << level)`, with `H = P/2`. The prescaler counter `cnt` is `$clog2(CLK_HZ/BASE_HZ)` bits wide.
- **Running** (`paused` = 0):
  - `cnt` increments each cycle.
  - At `cnt == P-1`, `cnt` wraps to 0, `tick` is registered high for the next cycle, and `clk_out` goes to 0.
  - At `cnt == H-1`, `clk_out` goes to 1.
- **Paused:** `cnt` and `clk_out` hold their values, and `tick` stays 0.
- **Level change (actual change only):**
  - On the next cycle, `cnt` is 0 and `clk_out` is 0, and no `tick` is issued for the interrupted period.
  - The new P applies from that cycle.
  - This restart takes priority over a same-cycle wrap.
- **Resume:** counting continues from the held `cnt`; the phase is preserved.
- **Reset values:** `cnt` 0, `level` 0, `paused` 0, `tick` 0, `clk_out` 0. All debounce counters are 0 and synchronizers are 1.
- **Reset mid-operation:** all outputs return to the reset values immediately (asynchronously). Any debounce in progress is discarded.

## Timing
- All outputs are registered, with no combinational path from inputs.
- **First tick after reset:** with `sys_rst` deasserted before edge 1, `tick` is high during the cycle following edge P, i.e. every P cycles thereafter.
- **Square wave:** `clk_out` rises H cycles after each wrap and falls at the wrap. Period P, high for H cycles.
- **Key latency:** from a raw key edge to the `level`/`paused` update, 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge detect/update) cycles.
- **Glitch rejection:** a key glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- **Spacing:** `tick` pulses are never closer than P(level) cycles apart, except for the first pulse after a level change, which arrives exactly P(new) cycles after the restart.

## Test plan
Bench parameters: `CLK_HZ`=16, `BASE_HZ`=1, `DEBOUNCE_CYCLES`=4, giving P = 16, 8, 4, 2 for levels 0 to 3.
1. **Reset and free run:** release reset, no keys → `tick` pulses every 16 cycles. `clk_out` is low for 8 cycles and high for 8. `level`=0, `paused`=0.
2. **Speed up:** hold `key_up` low for 10 cycles, three times, separated by 10 cycles high → `level` steps 1, 2, 3, each 7 cycles after the falling edge. Then `tick` repeats every 2 cycles and `clk_out` toggles every cycle. A fourth press leaves `level`=3 with no restart.
3. **Bounce rejection:** toggle `key_down` low/high every 2 cycles for 20 cycles, then hold high → `level` unchanged, no restart.
4. **Pause/resume:** press pause at `cnt`=5 (level 0) → `tick` absent and `clk_out` frozen while paused. After a second press, the next `tick` follows after the remaining 10 cycles (`cnt` continues from 6).
5. **Simultaneous up+down:** debounced press edges of up and down in the same cycle → `level` unchanged. Also raise `sys_rst` mid-period at level 2 → all outputs go to reset values asynchronously, and after release ticks resume every 16 cycles.

Source files
------------

// File: rtl/led_rate_tick_gen.sv
// Runtime-selectable step-rate generator for the running-light display: debounced
// up/down/pause keys choose one of four binary-scaled tick rates and a matching square wave.
`timescale 1ns / 1ps

module led_rate_tick_gen #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned BASE_HZ         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_key_up,
  input  logic       i_key_down,
  input  logic       i_key_pause,
  output logic       o_tick,
  output logic       o_clk_out,
  output logic [1:0] o_level,
  output logic       o_paused
);

  localparam int unsigned P0 = CLK_HZ / BASE_HZ;
  localparam int unsigned CW = $clog2(P0);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  if (CLK_HZ % (16 * BASE_HZ) != 0) begin : g_bad_clk_ratio
    $error("CLK_HZ must be a multiple of 16*BASE_HZ");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  // Key bit order: 0 = up, 1 = down, 2 = pause
  logic [2:0]    w_key_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_db_state;
  logic [2:0]    r_db_prev;
  logic [DW-1:0] r_db_cnt [3];
  logic [2:0]    w_press;

  logic [1:0]    r_level;
  logic [1:0]    w_level_next;
  logic          w_level_chg;
  logic          r_paused;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_pm1;
  logic [CW-1:0] w_hm1;
  logic          r_tick;
  logic          r_clk_out;

  assign w_key_raw = {i_key_pause, i_key_down, i_key_up};

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_db_state <= '1;
      r_db_prev  <= '1;
      for (int k = 0; k < 3; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1   <= w_key_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_state;
      for (int k = 0; k < 3; k++) begin
        if (r_sync2[k] == r_db_state[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_db_state[k] <= r_sync2[k];
          r_db_cnt[k]   <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DW'(1);
        end
      end
    end
  end

  // Active-low keys: a press is a 1->0 step of the debounced state
  assign w_press = r_db_prev & ~r_db_state;

  always_comb begin
    w_level_next = r_level;
    if (w_press[0] && !w_press[1] && r_level != 2'd3) begin
      w_level_next = r_level + 2'd1;
    end else if (w_press[1] && !w_press[0] && r_level != 2'd0) begin
      w_level_next = r_level - 2'd1;
    end
    w_level_chg = (w_level_next != r_level);
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_level  <= 2'd0;
      r_paused <= 1'b0;
    end else begin
      r_level <= w_level_next;
      if (w_press[2]) r_paused <= ~r_paused;
    end
  end

  always_comb begin
    w_pm1 = CW'(P0 - 1);
    w_hm1 = CW'(P0 / 2 - 1);
    case (r_level)
      2'd1: begin
        w_pm1 = CW'(P0 / 2 - 1);
        w_hm1 = CW'(P0 / 4 - 1);
      end
      2'd2: begin
        w_pm1 = CW'(P0 / 4 - 1);
        w_hm1 = CW'(P0 / 8 - 1);
      end
      2'd3: begin
        w_pm1 = CW'(P0 / 8 - 1);
        w_hm1 = CW'(P0 / 16 - 1);
      end
      default: ;
    endcase
  end

  // A real level change restarts the period and wins over a same-cycle wrap
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else if (w_level_chg) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else if (r_paused) begin
      r_tick <= 1'b0;
    end else if (r_cnt == w_pm1) begin
      r_cnt     <= '0;
      r_tick    <= 1'b1;
      r_clk_out <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
      if (r_cnt == w_hm1) r_clk_out <= 1'b1;
    end
  end

  assign o_tick    = r_tick;
  assign o_clk_out = r_clk_out;
  assign o_level   = r_level;
  assign o_paused  = r_paused;

endmodule

// File: tb/tb_led_rate_tick_gen.sv
// Cycle-by-cycle comparison of led_rate_tick_gen against a behavioural model of the
// key debounce rule, level/pause control and step-period phase.
`timescale 1ns / 1ps

module tb_led_rate_tick_gen;

  localparam int unsigned CLK_HZ  = 16;
  localparam int unsigned BASE_HZ = 1;
  localparam int unsigned DB      = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] keys;
  logic       tick;
  logic       clk_out;
  logic [1:0] level;
  logic       paused;

  always #5 clk = ~clk;

  led_rate_tick_gen #(
    .CLK_HZ         (CLK_HZ),
    .BASE_HZ        (BASE_HZ),
    .DEBOUNCE_CYCLES(DB)
  ) u_dut (
    .i_sys_clk  (clk),
    .i_sys_rst  (rst),
    .i_key_up   (keys[0]),
    .i_key_down (keys[1]),
    .i_key_pause(keys[2]),
    .o_tick     (tick),
    .o_clk_out  (clk_out),
    .o_level    (level),
    .o_paused   (paused)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase = cycles elapsed in the current step period
  int m_level;
  bit m_paused;
  int m_phase;
  bit m_tick;
  bit m_state [3];
  int m_run   [3];
  bit m_press [3];
  bit m_dly   [3][2];

  function automatic int period(input int l);
    return CLK_HZ / (BASE_HZ << l);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level  = 0;
    m_paused = 1'b0;
    m_phase  = 0;
    m_tick   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_state[k]  = 1'b1;
      m_run[k]    = 0;
      m_press[k]  = 1'b0;
      m_dly[k][0] = 1'b1;
      m_dly[k][1] = 1'b1;
    end
  endtask

  task automatic model_edge();
    int old_level;
    int new_level;
    bit seen;
    old_level = m_level;
    new_level = m_level;
    if (m_press[0] && !m_press[1] && m_level < 3) new_level = m_level + 1;
    else if (m_press[1] && !m_press[0] && m_level > 0) new_level = m_level - 1;
    if (new_level != old_level) begin
      m_phase = 0;
      m_tick  = 1'b0;
    end else if (m_paused) begin
      m_tick = 1'b0;
    end else begin
      m_phase++;
      m_tick = (m_phase == period(old_level));
      if (m_tick) m_phase = 0;
    end
    if (m_press[2]) m_paused = !m_paused;
    m_level = new_level;
    // A key is accepted once DB consecutive synchronized samples disagree with it
    for (int k = 0; k < 3; k++) begin
      seen        = m_dly[k][0];
      m_dly[k][0] = m_dly[k][1];
      m_dly[k][1] = keys[k];
      m_press[k]  = 1'b0;
      if (seen != m_state[k]) begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          m_state[k] = seen;
          m_run[k]   = 0;
          m_press[k] = !seen;
        end
      end else begin
        m_run[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("tick", 32'(tick), 32'(m_tick));
    check_eq("clk_out", 32'(clk_out), 32'(m_phase >= period(m_level) / 2));
    check_eq("level", 32'(level), 32'(m_level));
    check_eq("paused", 32'(paused), 32'(m_paused));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press_mask(input logic [2:0] mask, input int hold, input int gap);
    keys = ~mask;
    run(hold);
    keys = 3'b111;
    run(gap);
  endtask

  initial begin
    rst  = 1'b1;
    keys = 3'b111;
    model_reset();
    run(3);
    rst = 1'b0;
    run(48);

    // Speed up to level 3, then a saturated fourth press
    for (int i = 0; i < 3; i++) press_mask(3'b001, 10, 10);
    run(12);
    press_mask(3'b001, 10, 10);

    // Bouncing down key must not be accepted
    for (int i = 0; i < 5; i++) begin
      keys[1] = 1'b0;
      run(2);
      keys[1] = 1'b1;
      run(2);
    end
    run(12);

    // Back to level 0, then pause for a while and resume
    for (int i = 0; i < 3; i++) press_mask(3'b010, 10, 10);
    run(5);
    press_mask(3'b100, 10, 20);
    press_mask(3'b100, 10, 40);

    // Simultaneous up and down
    press_mask(3'b011, 10, 20);

    // Asynchronous reset mid-period at level 2
    press_mask(3'b001, 10, 10);
    press_mask(3'b001, 10, 5);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_clk_out", 32'(clk_out), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_paused", 32'(paused), 32'd0);
    model_reset();
    @(negedge clk);
    step();
    rst = 1'b0;
    run(40);

    // Randomized key activity, including overlapping and short presses
    for (int i = 0; i < 60; i++) begin
      press_mask(3'($urandom_range(1, 7)), $urandom_range(1, 10), $urandom_range(1, 12));
    end
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
